int_fp_mul_pipe: RTL and testbench
==================================

Name: int_fp_mul_pipe

Overview:
- Multi-lane, fully pipelined successor to the single-lane dual-mode (INT / FP16) multiplier.
- Each lane multiplies one operand pair in either signed-integer mode or FP16 mode; one mode applies to the whole beat.
- Valid/ready elastic pipeline, fixed 3-cycle latency, full throughput, sticky error accounting.
- Sits between the systolic-array PE operand buses and the accumulator stage.

Parameters:
- LANES, 4, number of independent multiplier lanes per beat.
- INT_W, 8, integer operand width (legal range 2..8). Product is sign-extended to 16 bits.
- TAG_W, 4, width of the sideband tag carried alongside each beat.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid & in_ready
- in_mode  in  1  1 = FP16, 0 = signed INT_W
- in_a  in  16*LANES  operand A, lane i = bits [16i+15:16i]
- in_b  in  16*LANES  operand B, same packing as in_a
- in_tag  in  TAG_W  sideband tag, returned unchanged
- out_valid  out  1  result beat valid
- out_ready  in  1  downstream accepts result
- out_c  out  16*LANES  products, same packing as operands
- out_err  out  LANES  per-lane error flag (FP16 mode only)
- out_mode  out  1  mode of the returned beat
- out_tag  out  TAG_W  tag of the returned beat
- clr_err  in  1  synchronous clear of err_count
- err_count  out  16  saturating count of flagged lane results

Behaviour:
- Reset (async): all stage valids 0; out_valid, out_c, out_err, out_mode, out_tag, err_count all 0. in_ready is 1 once the pipe is empty.
- Pipeline stages:
  - S1: unpack / sign and exponent add.
  - S2: 11x11 mantissa multiply or INT multiply.
  - S3: normalise / pack / error.
- Stage k loads when ~valid_k | ready_(k+1). in_ready = ~v1 | ready2, where ready3 = ~v3 | out_ready.
- Latency is exactly 3 cycles from input handshake to out_valid when there is no stall. Throughput is 1 beat per cycle.
- Order is preserved. A stall freezes all stage contents; no beat is lost or duplicated.
- Outputs (out_*) are registered in S3. out_* is stable while out_valid & ~out_ready.
- INT mode:
  - Lane uses a[INT_W-1:0] and b[INT_W-1:0] as two's complement; upper bits are ignored.
  - out_c = exact signed product, sign-extended to 16 bits. out_err = 0.
- FP16 mode, per lane, with sign = sa ^ sb:
  - Either exponent 31 with a nonzero mantissa (NaN), or inf times a zero/subnormal: out_c = 16'h7E00, err = 1.
  - Otherwise either exponent 31 (inf): out_c = {sign, 16'h7C00[14:0]}, err = 0.
  - Otherwise either exponent 0 (zero/subnormal, flushed): out_c = {sign, 15'b0}, err = 0.
  - Normal path:
    - e = ea + eb - 15, computed in signed 7-bit.
    - p = {1, ma} * {1, mb}, 22 bits.
    - If p[21]: e = e + 1, mantissa = p[20:11]; else mantissa = p[19:10]. Truncation (round toward zero).
    - e >= 31: signed inf, err = 1 (overflow).
    - e <= 0: signed zero, err = 1 (underflow).
    - Otherwise out_c = {sign, e[4:0], mantissa}.
- err_count:
  - On each output handshake, add popcount(out_err); saturate at 16'hFFFF.
  - clr_err has priority: a clear in the same cycle as a handshake yields 0 (that increment is dropped).
- Mode is per beat. Consecutive beats may alternate modes with no bubble.
- Reset asserted mid-stream discards all in-flight beats immediately. No partial beat appears after release.

Test Plan:
- FP16, all lanes a = 16'h3E00 (1.5), b = 16'h4000 (2.0) -> out_c lanes = 16'h4200, out_err = 0, out_valid exactly 3 cycles after handshake.
- INT, INT_W = 8:
  - lane0 a = 8'hF6 (-10), b = 8'h07 -> 16'hFFBA.
  - lane1 a = 8'h80, b = 8'h80 -> 16'h4000.
  - Upper operand bits set to 8'hFF are ignored. err = 0.
- FP16 errors:
  - 16'h7BFF * 16'h7BFF -> 16'h7C00, err = 1.
  - 16'h8400 * 16'h0400 -> 16'h8000, err = 1.
  - 16'h7C00 * 16'h0000 -> 16'h7E00, err = 1.
  - 16'hFC00 * 16'h3C00 -> 16'hFC00, err = 0.
  - err_count = 3 after these four lanes.
- Backpressure: stream 8 tagged beats (tags 0..7) of alternating mode; hold out_ready = 0 for 5 cycles mid-stream.
  - in_ready drops once 3 beats are held.
  - Outputs stay stable while stalled.
  - All 8 results are correct, in tag order.
- err_count: force a flagged lane each beat with err_count preloaded to 16'hFFFE -> saturates at 16'hFFFF. Pulse clr_err coincident with a flagged handshake -> 0.
- Reset mid-stream: assert rst_n low with 2 beats in flight -> out_valid = 0 and err_count = 0 asynchronously. After release, a fresh beat appears after exactly 3 cycles with no stale data.

Source files
------------

// File: rtl/int_fp_mul_pipe.sv
// Multi-lane INT / FP16 multiplier, three-stage elastic valid/ready pipeline.
// S1 unpacks operands and adds exponents, S2 multiplies, S3 normalises and
// packs into the registered outputs. A stall freezes every stage in place.
module int_fp_mul_pipe #(
  parameter int LANES = 4,
  parameter int INT_W = 8,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_mode,
  input  logic [16*LANES-1:0]  in_a,
  input  logic [16*LANES-1:0]  in_b,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [16*LANES-1:0]  out_c,
  output logic [LANES-1:0]     out_err,
  output logic                 out_mode,
  output logic [TAG_W-1:0]     out_tag,
  input  logic                 clr_err,
  output logic [15:0]          err_count
);

  localparam logic [1:0] CL_NORM = 2'd0;
  localparam logic [1:0] CL_ZERO = 2'd1;
  localparam logic [1:0] CL_INF  = 2'd2;
  localparam logic [1:0] CL_NAN  = 2'd3;

  // Special-case class of an FP16 operand pair; NaN also covers inf * zero.
  function automatic logic [1:0] fp_class(input logic [15:0] a, input logic [15:0] b);
    logic a_inf, b_inf, a_nan, b_nan, a_zero, b_zero;
    a_inf  = (a[14:10] == 5'd31) && (a[9:0] == 10'd0);
    b_inf  = (b[14:10] == 5'd31) && (b[9:0] == 10'd0);
    a_nan  = (a[14:10] == 5'd31) && (a[9:0] != 10'd0);
    b_nan  = (b[14:10] == 5'd31) && (b[9:0] != 10'd0);
    a_zero = (a[14:10] == 5'd0);
    b_zero = (b[14:10] == 5'd0);
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) fp_class = CL_NAN;
    else if (a_inf || b_inf)                                     fp_class = CL_INF;
    else if (a_zero || b_zero)                                   fp_class = CL_ZERO;
    else                                                         fp_class = CL_NORM;
  endfunction

  function automatic logic [15:0] int_ext(input logic [INT_W-1:0] x);
    int_ext = {{(16-INT_W){x[INT_W-1]}}, x};
  endfunction

  // Returns {err, result}; p_hi is product bits [21:10].
  function automatic logic [16:0] fp_pack(input logic sgn, input logic [1:0] cls,
                                          input logic [6:0] e_in, input logic [11:0] p_hi);
    logic [6:0] e;
    logic [9:0] m;
    e = e_in;
    m = p_hi[9:0];
    if (p_hi[11]) begin
      e = e_in + 7'd1;
      m = p_hi[10:1];
    end
    case (cls)
      CL_NAN:  fp_pack = {1'b1, 16'h7E00};
      CL_INF:  fp_pack = {1'b0, sgn, 15'h7C00};
      CL_ZERO: fp_pack = {1'b0, sgn, 15'h0000};
      default: begin
        if ($signed(e) >= 7'sd31)     fp_pack = {1'b1, sgn, 15'h7C00};
        else if ($signed(e) <= 7'sd0) fp_pack = {1'b1, sgn, 15'h0000};
        else                          fp_pack = {1'b0, sgn, e[4:0], m};
      end
    endcase
  endfunction

  logic ready1, ready2, ready3;
  logic v1, v2;
  logic mode1, mode2;
  logic [TAG_W-1:0] tag1, tag2;

  logic [LANES-1:0][15:0] lane_a, lane_b;
  logic [LANES-1:0]       sgn_n, sgn1, sgn2;
  logic [LANES-1:0][1:0]  cls_n, cls1, cls2;
  logic [LANES-1:0][6:0]  exp_n, exp1, exp2;
  logic [LANES-1:0][15:0] opa_n, opb_n, opa1, opb1;
  logic [LANES-1:0][21:0] prod_n, prod2;
  logic [LANES-1:0][15:0] c_n;
  logic [LANES-1:0]       err_n;
  logic [16:0]            cnt_sum;

  assign lane_a   = in_a;
  assign lane_b   = in_b;
  assign ready3   = ~out_valid | out_ready;
  assign ready2   = ~v2 | ready3;
  assign ready1   = ~v1 | ready2;
  assign in_ready = ready1;

  // S1 next state: classify, add exponents, select multiplier operands per mode.
  always_comb begin
    sgn_n = '0;
    cls_n = '0;
    exp_n = '0;
    opa_n = '0;
    opb_n = '0;
    for (int i = 0; i < LANES; i++) begin
      sgn_n[i] = lane_a[i][15] ^ lane_b[i][15];
      cls_n[i] = fp_class(lane_a[i], lane_b[i]);
      exp_n[i] = {2'b00, lane_a[i][14:10]} + {2'b00, lane_b[i][14:10]} - 7'd15;
      if (in_mode) begin
        opa_n[i] = {5'b0, 1'b1, lane_a[i][9:0]};
        opb_n[i] = {5'b0, 1'b1, lane_b[i][9:0]};
      end else begin
        opa_n[i] = int_ext(lane_a[i][INT_W-1:0]);
        opb_n[i] = int_ext(lane_b[i][INT_W-1:0]);
      end
    end
  end

  // S2 next state: one unsigned multiplier per lane serves both modes; the low
  // 16 bits of an unsigned product of sign-extended patterns equal the signed product.
  always_comb begin
    prod_n = '0;
    for (int i = 0; i < LANES; i++)
      prod_n[i] = {6'b0, opa1[i]} * {6'b0, opb1[i]};
  end

  // S3 next state: normalise and pack FP results, pass INT products through.
  always_comb begin
    c_n   = '0;
    err_n = '0;
    for (int i = 0; i < LANES; i++) begin
      if (mode2) {err_n[i], c_n[i]} = fp_pack(sgn2[i], cls2[i], exp2[i], prod2[i][21:10]);
      else       c_n[i] = prod2[i][15:0];
    end
  end

  // Stage 1 register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0; mode1 <= 1'b0; tag1 <= '0;
      sgn1 <= '0; cls1 <= '0; exp1 <= '0; opa1 <= '0; opb1 <= '0;
    end else if (ready1) begin
      v1 <= in_valid; mode1 <= in_mode; tag1 <= in_tag;
      sgn1 <= sgn_n; cls1 <= cls_n; exp1 <= exp_n; opa1 <= opa_n; opb1 <= opb_n;
    end
  end

  // Stage 2 register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2 <= 1'b0; mode2 <= 1'b0; tag2 <= '0;
      sgn2 <= '0; cls2 <= '0; exp2 <= '0; prod2 <= '0;
    end else if (ready2) begin
      v2 <= v1; mode2 <= mode1; tag2 <= tag1;
      sgn2 <= sgn1; cls2 <= cls1; exp2 <= exp1; prod2 <= prod_n;
    end
  end

  // Stage 3 register drives the outputs directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0; out_c <= '0; out_err <= '0; out_mode <= 1'b0; out_tag <= '0;
    end else if (ready3) begin
      out_valid <= v2; out_c <= c_n; out_err <= err_n; out_mode <= mode2; out_tag <= tag2;
    end
  end

  assign cnt_sum = {1'b0, err_count} + 17'($countones(out_err));

  // Sticky error counter; a clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      err_count <= 16'h0000;
    else if (clr_err)                err_count <= 16'h0000;
    else if (out_valid && out_ready) err_count <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end

endmodule

// File: tb/tb_int_fp_mul_pipe.sv
// Self-checking bench for int_fp_mul_pipe: directed steps plus random traffic
// scored against an arithmetic reference model and an in-order expectation queue.
module tb_int_fp_mul_pipe;
  localparam int LANES = 4;
  localparam int INT_W = 8;
  localparam int TAG_W = 4;

  logic clk, rst_n, in_valid, in_ready, in_mode, out_valid, out_ready, out_mode, clr_err;
  logic [63:0] in_a, in_b, out_c;
  logic [3:0]  in_tag, out_tag, out_err;
  logic [15:0] err_count;

  int total = 0;
  int bad   = 0;
  int n_out = 0;

  typedef struct {
    logic [63:0] c;
    logic [3:0]  err;
    logic        mode;
    logic [3:0]  tag;
  } beat_t;

  beat_t       q[$];
  int          exp_cnt = 0;
  bit          have_prev = 0;
  logic [63:0] prev_c;
  logic [3:0]  prev_err, prev_tag;
  logic        prev_mode;

  int_fp_mul_pipe #(.LANES(LANES), .INT_W(INT_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_c(out_c),
    .out_err(out_err), .out_mode(out_mode), .out_tag(out_tag),
    .clr_err(clr_err), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference for one lane, returns {err, result}.
  function automatic logic [16:0] ref_lane(input logic mode, input logic [15:0] a, input logic [15:0] b);
    int sa, sb, ea, eb, ma, mb, e, m, p;
    logic s;
    logic [31:0] pv;
    if (!mode) begin
      sa = int'(a[INT_W-1:0]);
      sb = int'(b[INT_W-1:0]);
      if (sa >= (1 << (INT_W-1))) sa -= (1 << INT_W);
      if (sb >= (1 << (INT_W-1))) sb -= (1 << INT_W);
      pv = sa * sb;
      return {1'b0, pv[15:0]};
    end
    s  = a[15] ^ b[15];
    ea = int'(a[14:10]); eb = int'(b[14:10]);
    ma = int'(a[9:0]);   mb = int'(b[9:0]);
    if ((ea == 31 && ma != 0) || (eb == 31 && mb != 0) ||
        (ea == 31 && eb == 0) || (eb == 31 && ea == 0)) return {1'b1, 16'h7E00};
    if (ea == 31 || eb == 31) return {1'b0, s, 15'h7C00};
    if (ea == 0 || eb == 0)   return {1'b0, s, 15'h0000};
    e = ea + eb - 15;
    p = (1024 + ma) * (1024 + mb);
    if (p >= (1 << 21)) begin
      e = e + 1;
      m = (p / 2048) % 1024;
    end else begin
      m = (p / 1024) % 1024;
    end
    if (e >= 31) return {1'b1, s, 15'h7C00};
    if (e <= 0)  return {1'b1, s, 15'h0000};
    pv = e * 1024 + m;
    return {1'b0, s, pv[14:0]};
  endfunction

  function automatic beat_t ref_beat(input logic mode, input logic [63:0] a, input logic [63:0] b,
                                     input logic [3:0] tag);
    beat_t bt;
    logic [16:0] r;
    bt.mode = mode;
    bt.tag  = tag;
    bt.c    = '0;
    bt.err  = '0;
    for (int i = 0; i < LANES; i++) begin
      r = ref_lane(mode, a[16*i +: 16], b[16*i +: 16]);
      bt.c[16*i +: 16] = r[15:0];
      bt.err[i]        = r[16];
    end
    return bt;
  endfunction

  function automatic logic [63:0] rnd_op();
    logic [63:0] v;
    logic [31:0] r;
    for (int i = 0; i < LANES; i++) begin
      r = $urandom;
      case ($urandom_range(0, 7))
        0:       v[16*i +: 16] = {r[15], 15'h7C00};
        1:       v[16*i +: 16] = {r[15], 5'd0, r[9:0]};
        2:       v[16*i +: 16] = {r[15], 5'd31, r[9:0] | 10'd1};
        3:       v[16*i +: 16] = {r[15], 2'b00, r[12:0]};
        4:       v[16*i +: 16] = {r[15], 2'b11, r[12:0]};
        default: v[16*i +: 16] = r[15:0];
      endcase
    end
    return v;
  endfunction

  // Scoreboard / monitor, sampled on the falling edge.
  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      q.delete();
      exp_cnt   = 0;
      have_prev = 0;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_err_count", err_count, 16'h0000);
    end else begin
      chk("err_count", err_count, exp_cnt);
      if (have_prev) begin
        chk("stall_valid", out_valid, 1'b1);
        chk("stall_c", out_c, prev_c);
        chk("stall_err", out_err, prev_err);
        chk("stall_tag", out_tag, prev_tag);
        chk("stall_mode", out_mode, prev_mode);
      end
      if (clr_err) exp_cnt = 0;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_out", out_valid, 1'b0);
        end else begin
          e = q.pop_front();
          n_out++;
          chk("out_c", out_c, e.c);
          chk("out_err", out_err, e.err);
          chk("out_mode", out_mode, e.mode);
          chk("out_tag", out_tag, e.tag);
          if (!clr_err) begin
            exp_cnt = exp_cnt + $countones(e.err);
            if (exp_cnt > 65535) exp_cnt = 65535;
          end
        end
      end
      have_prev = out_valid && !out_ready;
      prev_c = out_c; prev_err = out_err; prev_tag = out_tag; prev_mode = out_mode;
      if (in_valid && in_ready) q.push_back(ref_beat(in_mode, in_a, in_b, in_tag));
    end
  end

  task automatic send(input logic mode, input logic [63:0] a, input logic [63:0] b,
                      input logic [3:0] tag, input bit rnd_rdy);
    bit hs, done;
    in_mode = mode; in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
    done = 0;
    for (int k = 0; k < 100 && !done; k++) begin
      if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
      #1;
      hs = in_ready;
      @(posedge clk); #1;
      done = hs;
    end
    in_valid = 1'b0;
    chk("send_handshake", done, 1'b1);
  endtask

  task automatic wait_out();
    for (int k = 0; k < 50 && !out_valid; k++) begin
      @(posedge clk); #1;
    end
    chk("wait_out", out_valid, 1'b1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int k = 0; k < 60 && (q.size() != 0 || out_valid); k++) begin
      @(posedge clk); #1;
    end
    chk("drain", q.size(), 0);
  endtask

  // One beat into an empty pipe; out_valid must rise on the third edge exactly.
  task automatic lat_beat(input logic mode, input logic [63:0] a, input logic [63:0] b,
                          input logic [3:0] tag);
    out_ready = 1'b1;
    in_mode = mode; in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
    #1;
    chk("lat_in_ready", in_ready, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk($sformatf("lat_cycle%0d", k), out_valid, (k == 3));
    end
  endtask

  initial begin
    logic [63:0] ba[8], bb[8];
    logic [63:0] f4;
    int idx, n0;
    bit hs;

    rst_n = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_a = '0; in_b = '0; in_tag = '0;
    out_ready = 1'b0; clr_err = 1'b0;
    f4 = {4{16'h7BFF}};
    #2 rst_n = 1'b0;
    #1;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_out_c", out_c, 64'h0);
    chk("reset_out_err", out_err, 4'h0);
    chk("reset_out_tag", out_tag, 4'h0);
    chk("reset_out_mode", out_mode, 1'b0);
    chk("reset_err_count", err_count, 16'h0);
    chk("reset_in_ready", in_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // FP16 1.5 * 2.0 with latency check.
    lat_beat(1'b1, {4{16'h3E00}}, {4{16'h4000}}, 4'd1);
    chk("fp_basic_c", out_c, {4{16'h4200}});
    chk("fp_basic_err", out_err, 4'h0);

    // INT mode with junk in the upper operand bits.
    send(1'b0, {16'h007F, 16'h0005, 16'hFF80, 16'hFFF6},
               {16'h007F, 16'h00FD, 16'hFF80, 16'hFF07}, 4'd2, 0);
    wait_out();
    chk("int_c", out_c, {16'h3F01, 16'hFFF1, 16'h4000, 16'hFFBA});
    chk("int_err", out_err, 4'h0);

    // FP16 special and range-error lanes.
    send(1'b1, {16'hFC00, 16'h7C00, 16'h8400, 16'h7BFF},
               {16'h3C00, 16'h0000, 16'h0400, 16'h7BFF}, 4'd3, 0);
    wait_out();
    chk("fperr_c", out_c, {16'hFC00, 16'h7E00, 16'h8000, 16'h7C00});
    chk("fperr_err", out_err, 4'b0111);
    @(posedge clk); #1;
    chk("fperr_count", err_count, 16'd3);

    // Random traffic with random backpressure and idle gaps.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        out_ready = ($urandom_range(0, 1) != 0);
        @(posedge clk); #1;
      end
      send(1'($urandom_range(0, 1)), rnd_op(), rnd_op(), 4'(n), 1);
    end
    drain();

    // Eight tagged beats of alternating mode with a 5-cycle output stall.
    for (int i = 0; i < 8; i++) begin
      ba[i] = rnd_op();
      bb[i] = rnd_op();
    end
    n0 = n_out;
    idx = 0;
    for (int c = 0; c < 40 && idx < 8; c++) begin
      in_valid = 1'b1; in_mode = idx[0]; in_a = ba[idx]; in_b = bb[idx]; in_tag = 4'(idx);
      out_ready = !(c >= 4 && c < 9);
      #1;
      if (c == 6) chk("bp_in_ready_low", in_ready, 1'b0);
      hs = in_ready;
      @(posedge clk); #1;
      if (hs) idx++;
    end
    in_valid = 1'b0;
    chk("bp_all_sent", idx, 8);
    drain();
    chk("bp_all_received", n_out - n0, 8);

    // Saturation of err_count, then clear racing a flagged handshake.
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
    chk("clr_idle", err_count, 16'h0);
    for (int n = 0; n < 16383; n++) send(1'b1, f4, f4, 4'(n), 0);
    send(1'b1, {16'h3C00, 16'h3C00, 16'h7BFF, 16'h7BFF},
               {16'h3C00, 16'h3C00, 16'h7BFF, 16'h7BFF}, 4'd5, 0);
    drain();
    chk("preload_fffe", err_count, 16'hFFFE);
    send(1'b1, f4, f4, 4'd6, 0);
    drain();
    chk("saturate_ffff", err_count, 16'hFFFF);
    send(1'b1, f4, f4, 4'd7, 0);
    wait_out();
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
    chk("clr_with_handshake", err_count, 16'h0);
    drain();

    // Reset with two beats in flight.
    send(1'b1, f4, f4, 4'd8, 0);
    drain();
    chk("pre_reset_count", err_count, 16'd4);
    out_ready = 1'b0;
    send(1'b1, f4, f4, 4'd10, 0);
    send(1'b0, rnd_op(), rnd_op(), 4'd11, 0);
    wait_out();
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_err_count", err_count, 16'h0);
    chk("midrst_in_ready", in_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    lat_beat(1'b0, rnd_op(), rnd_op(), 4'd9);
    chk("post_rst_tag", out_tag, 4'd9);
    drain();
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_idle", out_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
